adder_seq_ctrl: RTL

//   Sequencer that runs a WORDS*32-bit addition through one external 32-bit Adder.
//   It works least-significant word first, one word per clock, and chains the carry in a register.
//   It owns the Adder's a/b/ci inputs and captures its s/co outputs.

---
 rtl/adder_seq_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - word-serial WORDS*32-bit adder sequencer driving one external 32-bit adder
module adder_seq_ctrl #(
  parameter int WORDS = 4,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_ci,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_co,
  output logic [31:0]           add_a,
  output logic [31:0]           add_b,
  output logic                  add_ci,
  input  logic [31:0]           add_s,
  input  logic                  add_co
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_next;
  logic [IDXW-1:0]       idx;
  logic                  carry;
  logic [32*WORDS-1:0]   a_reg, b_reg;
  logic                  last;

  assign last = (idx == IDXW'(WORDS-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Adder inputs are only driven while a word is being processed
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    add_a      = 32'd0;
    add_b      = 32'd0;
    add_ci     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        add_a  = a_reg[32*idx +: 32];
        add_b  = b_reg[32*idx +: 32];
        add_ci = carry;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      carry   <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_sum <= '0;
      out_co  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= in_b;
            carry <= in_ci;
            idx   <= '0;
          end
        end
        RUN: begin
          out_sum[32*idx +: 32] <= add_s;
          carry                 <= add_co;
          // Park idx at 0 after the top word so it never leaves 0..WORDS-1
          if (last) begin
            out_co <= add_co;
            idx    <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
